// File: rtl/uart_defs_pkg.sv
// Shared UART TX definitions: frame state encodings, line levels and parity helper.
// Used by uart_tx_ctrl and by the downstream TX data multiplexer.
package uart_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic TX_IDLE  = 1'b1;
  localparam logic TX_START = 1'b0;
  localparam logic TX_STOP  = 1'b1;

  // Even parity is the XOR of the byte; odd parity is its complement.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    calc_parity = odd ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time counter: counts 0..BIT_CNT-1 while enabled and flags the last cycle of a bit.
module uart_baud_counter #(
  parameter int BIT_CNT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int W = $clog2(BIT_CNT);
  localparam logic [W-1:0] LAST = W'(BIT_CNT - 1);

  logic [W-1:0] cnt_q;

  assign wrap = en && (cnt_q == LAST);

  // Free-running bit counter, held at zero while cleared and restarting after the last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= wrap ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: accepts a byte on a start/busy handshake and walks
// START, eight data bits (LSB first), optional parity and STOP, emitting a
// bit-boundary strobe that the TX data multiplexer registers the line on.
module uart_tx_ctrl
  import uart_defs::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_din,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [2:0] tx_state,
  output logic [7:0] tx_data,
  output logic [2:0] tx_data_index,
  output logic       tx_parity,
  output logic       end_bit_time
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;

  tx_state_e  state_q;
  logic [7:0] data_q;
  logic [2:0] idx_q;
  logic       par_q;
  logic       ebt_q;
  logic       busy_q;
  logic       done_q;

  logic running;
  logic wrap;

  // The counter only runs inside a frame; in IDLE (or an illegal code) it is held at zero
  // so the START bit always begins a fresh bit time.
  assign running = (state_q == ST_START) || (state_q == ST_DATA) ||
                   (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_baud_counter #(
    .BIT_CNT(BIT_CNT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!running),
    .en   (running),
    .wrap (wrap)
  );

  // Frame FSM with registered strobe, handshake, index and byte/parity latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      ebt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ebt_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tx_start && !busy_q) begin
            state_q <= ST_START;
            data_q  <= tx_din;
            par_q   <= calc_parity(tx_din, PARITY_ODD != 0);
            idx_q   <= '0;
            ebt_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (wrap) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
            ebt_q   <= 1'b1;
          end
        end
        ST_DATA: begin
          if (wrap) begin
            ebt_q <= 1'b1;
            if (idx_q == 3'd7) begin
              state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (wrap) begin
            state_q <= ST_STOP;
            ebt_q   <= 1'b1;
          end
        end
        ST_STOP: begin
          if (wrap) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ebt_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          // Recover from a corrupted state code silently: no strobe, no done.
          state_q <= ST_IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_state      = state_q;
  assign tx_data       = data_q;
  assign tx_data_index = idx_q;
  assign tx_parity     = par_q;
  assign end_bit_time  = ebt_q;
  assign tx_busy       = busy_q;
  assign tx_done       = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: three configurations (even parity, odd parity,
// no parity) at BIT_CNT=10, each feeding a small TX data mux model for the line.
module tb_uart_tx_ctrl;
  import uart_defs::*;

  logic       clk;
  logic       rst_n;
  logic       start [3];
  logic [7:0] din   [3];
  logic       busy  [3];
  logic       done  [3];
  logic [2:0] st    [3];
  logic [7:0] data  [3];
  logic [2:0] idx   [3];
  logic       par   [3];
  logic       ebt   [3];
  logic [2:0] line;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLK_FREQ(1000), .BAUD(100), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_start(start[0]), .tx_din(din[0]), .tx_busy(busy[0]),
    .tx_done(done[0]), .tx_state(st[0]), .tx_data(data[0]), .tx_data_index(idx[0]),
    .tx_parity(par[0]), .end_bit_time(ebt[0]));

  uart_tx_ctrl #(.CLK_FREQ(1000), .BAUD(100), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_start(start[1]), .tx_din(din[1]), .tx_busy(busy[1]),
    .tx_done(done[1]), .tx_state(st[1]), .tx_data(data[1]), .tx_data_index(idx[1]),
    .tx_parity(par[1]), .end_bit_time(ebt[1]));

  uart_tx_ctrl #(.CLK_FREQ(1000), .BAUD(100), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
    .clk(clk), .rst_n(rst_n), .tx_start(start[2]), .tx_din(din[2]), .tx_busy(busy[2]),
    .tx_done(done[2]), .tx_state(st[2]), .tx_data(data[2]), .tx_data_index(idx[2]),
    .tx_parity(par[2]), .end_bit_time(ebt[2]));

  // Downstream TX data mux model: registers the line on each bit strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= 3'b111;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ebt[i]) begin
          case (st[i])
            3'd1:    line[i] <= TX_START;
            3'd2:    line[i] <= data[i][idx[i]];
            3'd3:    line[i] <= par[i];
            3'd4:    line[i] <= TX_STOP;
            default: line[i] <= TX_IDLE;
          endcase
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Send one frame on unit u and check every strobe, the gaps between them and the line.
  // Returns one cycle after the IDLE strobe. hold keeps tx_start high at the end;
  // poke pulses a second request with a different byte mid-frame.
  task automatic frame(input int u, input logic [7:0] b, input logic par_exp,
                       input bit pen, input bit hold, input bit poke);
    logic [2:0] es [12];
    logic [2:0] ei [12];
    logic       el [12];
    int ns;
    int k;
    int gap_bad;
    int par_seen;
    ns = pen ? 12 : 11;
    es[0] = 3'd1; ei[0] = 3'd0; el[0] = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      es[j] = 3'd2; ei[j] = 3'(j - 1); el[j] = b[j-1];
    end
    if (pen) begin
      es[9] = 3'd3; ei[9] = 3'd7; el[9] = par_exp;
    end
    es[ns-2] = 3'd4; ei[ns-2] = 3'd7; el[ns-2] = 1'b1;
    es[ns-1] = 3'd0; ei[ns-1] = 3'd0; el[ns-1] = 1'b1;

    @(negedge clk);
    start[u] = 1'b1;
    din[u]   = b;
    @(negedge clk);
    if (!hold) begin
      start[u] = 1'b0;
      din[u]   = ~b;
    end
    check("start_state", 32'(st[u]), 32'd1);
    check("start_ebt",   32'(ebt[u]), 32'd1);
    check("start_busy",  32'(busy[u]), 32'd1);
    check("start_data",  32'(data[u]), 32'(b));
    check("start_par",   32'(par[u]), 32'(par_exp));
    gap_bad  = 0;
    par_seen = 0;
    for (int cyc = 1; cyc <= (ns - 1) * 10; cyc++) begin
      @(negedge clk);
      if (poke && cyc == 35) begin
        start[u] = 1'b1;
        din[u]   = 8'h3C;
      end
      if (poke && cyc == 36) begin
        start[u] = 1'b0;
      end
      if (st[u] == 3'd3) par_seen++;
      if (cyc % 10 == 0) begin
        k = cyc / 10;
        check("strobe_ebt",   32'(ebt[u]), 32'd1);
        check("strobe_state", 32'(st[u]), 32'(es[k]));
        check("strobe_idx",   32'(idx[u]), 32'(ei[k]));
        check("strobe_busy",  32'(busy[u]), (k == ns - 1) ? 32'd0 : 32'd1);
        check("strobe_done",  32'(done[u]), (k == ns - 1) ? 32'd1 : 32'd0);
        check("frame_data",   32'(data[u]), 32'(b));
      end else begin
        if (ebt[u] !== 1'b0 || done[u] !== 1'b0) gap_bad++;
      end
      if (cyc % 10 == 1) begin
        check("line_bit", 32'(line[u]), 32'(el[(cyc - 1) / 10]));
      end
    end
    check("gap_quiet", 32'(gap_bad), 32'd0);
    if (!pen) check("no_parity_state", 32'(par_seen), 32'd0);
    @(negedge clk);
    check("line_idle", 32'(line[u]), 32'd1);
  endtask

  initial begin
    int bad;
    int waited;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      din[i]   = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(st[0]), 32'd0);
    check("rst_data",  32'(data[0]), 32'd0);
    check("rst_idx",   32'(idx[0]), 32'd0);
    check("rst_par",   32'(par[0]), 32'd0);
    check("rst_ebt",   32'(ebt[0]), 32'd0);
    check("rst_busy",  32'(busy[0]), 32'd0);
    check("rst_done",  32'(done[0]), 32'd0);
    check("rst_line",  32'(line), 32'h7);
    rst_n = 1'b1;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (ebt[0] !== 1'b0 || busy[0] !== 1'b0 || st[0] !== 3'd0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // 0xA5 even parity: line 0,1,0,1,0,0,1,0,1,0,1
    frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    // Odd parity of 0x03 is 1
    frame(1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    // No parity: 100-cycle frame, state 3 never appears
    frame(2, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    // Mid-frame request with 0x3C is ignored
    frame(0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b1);

    // Back-to-back: tx_start held through the IDLE strobe
    frame(0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0);
    check("b2b_state", 32'(st[0]), 32'd1);
    check("b2b_ebt",   32'(ebt[0]), 32'd1);
    check("b2b_busy",  32'(busy[0]), 32'd1);
    check("b2b_data",  32'(data[0]), 32'h81);
    start[0] = 1'b0;
    waited = 0;
    while (done[0] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("b2b_done_time", 32'(waited), 32'd110);
    @(negedge clk);

    // Reset in the middle of data bit 4
    start[0] = 1'b1;
    din[0]   = 8'hC3;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (53) @(negedge clk);
    check("pre_rst_state", 32'(st[0]), 32'd2);
    check("pre_rst_idx",   32'(idx[0]), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(st[0]), 32'd0);
    check("mid_rst_busy",  32'(busy[0]), 32'd0);
    check("mid_rst_ebt",   32'(ebt[0]), 32'd0);
    check("mid_rst_line",  32'(line[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
